// File: rtl/memora_rom.sv
// -----------------------------------------------------------------------------
// memora_rom
// Program ROM for the single-cycle manu-pu controller. The program counter
// selects a 16-bit instruction word combinationally (zero latency), because the
// PC update and the decode of the fetched word happen in the same cycle.
// Fetches beyond the implemented depth return NOP and set a sticky error flag.
//
// Ports:
//   clk         in   system clock (only the error flag is clocked)
//   rst_n       in   asynchronous active-low reset
//   counter     in   [AW-1:0]    fetch address (program counter)
//   instruccion out  [WIDTH-1:0] instruction word at counter (NOP in reset or
//                                when counter is out of range)
//   addr_err    out  sticky flag: an out-of-range address was fetched
//
// Instruction word layout:
//   [15] MB, [14] ~RW, [13] MD/JB, [12:9] FS (BC = [11:9]),
//   [8:6] D, [5:3] A, [2:0] B; branch offset AD = {D,B}, 6-bit signed.
// -----------------------------------------------------------------------------
module memora_rom #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 16,
   parameter int AW    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    counter,
   output logic [WIDTH-1:0] instruccion,
   output logic             addr_err
);

   localparam logic [WIDTH-1:0] NOP = '0;

   // Fixed program image. Any address without an explicit entry is NOP, which
   // also covers the fill region 6..DEPTH-1.
   function automatic logic [WIDTH-1:0] rom_word(input logic [AW-1:0] addr);
      logic [WIDTH-1:0] w;
      w = NOP;
      case (addr)
         AW'(0): w = WIDTH'(16'h8443); // ADI R1 = R0 + 3
         AW'(1): w = WIDTH'(16'h8481); // ADI R2 = R0 + 1
         AW'(2): w = WIDTH'(16'h0A4A); // SUB R1 = R1 - R2
         AW'(3): w = WIDTH'(16'hCFC7); // branch if not Z, AD = -1 -> addr 2
         AW'(4): w = WIDTH'(16'h4001); // store M[R0] <= R1
         AW'(5): w = WIDTH'(16'hE000); // jump to R0
         default: w = NOP;
      endcase
      return w;
   endfunction

   // Compare against DEPTH at full address width so there is no aliasing:
   // e.g. 64 or 0xFFFF never fold back onto a low word.
   logic in_range;
   logic addr_err_d;
   logic addr_err_q;

   always_comb begin
      in_range = ({1'b0, counter} < (AW + 1)'(DEPTH));
   end

   always_comb begin
      instruccion = NOP;
      if (rst_n && in_range) begin
         instruccion = rom_word(counter);
      end
   end

   always_comb begin
      addr_err_d = addr_err_q | ~in_range;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= addr_err_d;
      end
   end

   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_memora_rom.sv
module tb_memora_rom;

   logic        clk;
   logic        rst_n;
   logic [15:0] counter;
   logic [15:0] instruccion;
   logic        addr_err;

   int n_checks;
   int n_fail;

   logic [15:0] exp_prog [6];

   memora_rom #(.DEPTH(64), .WIDTH(16), .AW(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .counter     (counter),
      .instruccion (instruccion),
      .addr_err    (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      counter = 16'd0;
      #1;
      n_checks++;
      if (instruccion !== 16'h0000) begin
         $display("FAIL reset_instr: got %h expected %h", instruccion, 16'h0000); n_fail++;
      end
      n_checks++;
      if (addr_err !== 1'b0) begin
         $display("FAIL reset_err: got %b expected %b", addr_err, 1'b0); n_fail++;
      end
      // Out-of-range address held in reset must not set the flag.
      counter = 16'd64;
      tick();
      n_checks++;
      if (addr_err !== 1'b0) begin
         $display("FAIL reset_err_hold: got %b expected %b", addr_err, 1'b0); n_fail++;
      end
      counter = 16'd0;
      #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (instruccion !== 16'h8443) begin
         $display("FAIL release_instr: got %h expected %h", instruccion, 16'h8443); n_fail++;
      end
   endtask

   task automatic test_program_sweep();
      for (int i = 0; i < 6; i++) begin
         counter = 16'(i);
         #1;
         n_checks++;
         if (instruccion !== exp_prog[i]) begin
            $display("FAIL sweep_addr%0d: got %h expected %h", i, instruccion, exp_prog[i]); n_fail++;
         end
      end
      tick();
      n_checks++;
      if (addr_err !== 1'b0) begin
         $display("FAIL sweep_err: got %b expected %b", addr_err, 1'b0); n_fail++;
      end
   endtask

   task automatic test_fill();
      logic [15:0] addrs [3];
      addrs = '{16'd6, 16'd31, 16'd63};
      for (int i = 0; i < 3; i++) begin
         counter = addrs[i];
         tick();
         n_checks++;
         if (instruccion !== 16'h0000) begin
            $display("FAIL fill_instr_%0d: got %h expected %h", addrs[i], instruccion, 16'h0000); n_fail++;
         end
         n_checks++;
         if (addr_err !== 1'b0) begin
            $display("FAIL fill_err_%0d: got %b expected %b", addrs[i], addr_err, 1'b0); n_fail++;
         end
      end
   endtask

   task automatic test_out_of_range();
      counter = 16'd64;
      #1;
      n_checks++;
      if (instruccion !== 16'h0000) begin
         $display("FAIL oor_instr: got %h expected %h", instruccion, 16'h0000); n_fail++;
      end
      n_checks++;
      if (addr_err !== 1'b0) begin
         $display("FAIL oor_err_before_edge: got %b expected %b", addr_err, 1'b0); n_fail++;
      end
      tick();
      n_checks++;
      if (addr_err !== 1'b1) begin
         $display("FAIL oor_err_set: got %b expected %b", addr_err, 1'b1); n_fail++;
      end
      counter = 16'd1;
      tick();
      n_checks++;
      if (instruccion !== 16'h8481) begin
         $display("FAIL oor_after_instr: got %h expected %h", instruccion, 16'h8481); n_fail++;
      end
      n_checks++;
      if (addr_err !== 1'b1) begin
         $display("FAIL oor_sticky: got %b expected %b", addr_err, 1'b1); n_fail++;
      end
   endtask

   task automatic test_extreme();
      // Clear the flag between edges so the extreme address is seen on its own.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      counter = 16'hFFFF;
      #1;
      n_checks++;
      if (instruccion !== 16'h0000) begin
         $display("FAIL ext_instr: got %h expected %h", instruccion, 16'h0000); n_fail++;
      end
      n_checks++;
      if (addr_err !== 1'b0) begin
         $display("FAIL ext_err_cleared: got %b expected %b", addr_err, 1'b0); n_fail++;
      end
      tick();
      n_checks++;
      if (addr_err !== 1'b1) begin
         $display("FAIL ext_err_set: got %b expected %b", addr_err, 1'b1); n_fail++;
      end
      counter = 16'h00C3; // would alias to word 3 if the address were truncated
      #1;
      n_checks++;
      if (instruccion !== 16'h0000) begin
         $display("FAIL alias_instr: got %h expected %h", instruccion, 16'h0000); n_fail++;
      end
   endtask

   task automatic test_async_reset();
      counter = 16'd3;
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (addr_err !== 1'b0) begin
         $display("FAIL async_err: got %b expected %b", addr_err, 1'b0); n_fail++;
      end
      n_checks++;
      if (instruccion !== 16'h0000) begin
         $display("FAIL async_instr: got %h expected %h", instruccion, 16'h0000); n_fail++;
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (instruccion !== 16'hCFC7) begin
         $display("FAIL async_release_instr: got %h expected %h", instruccion, 16'hCFC7); n_fail++;
      end
      tick();
      n_checks++;
      if (addr_err !== 1'b0) begin
         $display("FAIL async_release_err: got %b expected %b", addr_err, 1'b0); n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_prog = '{16'h8443, 16'h8481, 16'h0A4A, 16'hCFC7, 16'h4001, 16'hE000};
      test_reset();
      test_program_sweep();
      test_fill();
      test_out_of_range();
      test_extreme();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memora_rom.md
Name: memora_rom

Overview:
- Program ROM for the single-cycle controller of the manu-pu processor.
- Maps the 16-bit program counter to a 16-bit instruction word, which feeds the instruction decoder.
- Reads are combinational with zero latency, because the PC updates and the instruction is decoded within the same cycle.
- Also holds a sticky out-of-range fetch flag, the only clocked state in the block.

Parameters:
- DEPTH, 64, number of implemented instruction words; valid addresses are 0..DEPTH-1.
- WIDTH, 16, instruction word width.
- AW, 16, address width (matches the PC).

Ports:
- clk  input  1  system clock; only the error flag is clocked.
- rst_n  input  1  reset; asynchronous, active-low.
- counter  input  AW  fetch address (program counter value).
- instruccion  output  WIDTH  instruction word at counter.
- addr_err  output  1  sticky flag: an out-of-range address was fetched.

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low.
- While rst_n=0: instruccion=0x0000 (NOP) regardless of counter, and addr_err=0.
- Read path, rst_n=1: purely combinational, zero latency. instruccion=MEM[counter] whenever counter<DEPTH.
- Out-of-range read, rst_n=1: for counter>=DEPTH, instruccion=0x0000 (NOP). There is no address wrap or aliasing; for example, address 64 does not return word 0.
- addr_err sets at the posedge clk when rst_n=1 and counter>=DEPTH.
  - Once set, it stays 1 until rst_n goes low.
  - If rst_n asserts mid-cycle, addr_err clears immediately (asynchronous).
- Contents are fixed at elaboration and the block has no write port. Field layout of each word:
  - MB = bit 15
  - bit 14 = ~RW
  - MD/JB = bit 13
  - FS = bits 12:9 (BC = bits 11:9)
  - D = bits 8:6
  - A = bits 5:3
  - B = bits 2:0
  - Branch offset AD = {D,B}, 6-bit signed.
- Required program contents:
  - addr 0: 0x8443, ADI R1=R0+3
  - addr 1: 0x8481, ADI R2=R0+1
  - addr 2: 0x0A4A, SUB R1=R1-R2 (FS=0101)
  - addr 3: 0xCFC7, branch if NOT Z, AD=-1 (target addr 2)
  - addr 4: 0x4001, store M[R0]<=R1
  - addr 5: 0xE000, jump to R0
  - addr 6..DEPTH-1: 0x0000
- Output changes only as a function of counter and rst_n; there are no glitch or registering requirements on instruccion.

Test Plan:
- Reset: rst_n=0 with counter=0 -> instruccion=0x0000 and addr_err=0. Release rst_n with counter=0 -> instruccion=0x8443 in the same delta, no clock edge needed.
- Program sweep: counter=0..5 with rst_n=1 -> instruccion=0x8443, 0x8481, 0x0A4A, 0xCFC7, 0x4001, 0xE000 respectively, checked before any clock edge. addr_err stays 0.
- Fill region: counter=6, 31 and 63 -> instruccion=0x0000 and addr_err=0 after clocking.
- Out-of-range: counter=64 -> instruccion=0x0000 immediately, and addr_err=1 after the next posedge clk. Then set counter=1 and clock -> instruccion=0x8481 while addr_err stays 1 (sticky).
- Extreme address: counter=0xFFFF -> instruccion=0x0000, and addr_err=1 after the posedge clk. There is no wrap to word 0x003F or word 0.
- Asynchronous reset mid-cycle: with addr_err=1, drop rst_n between clock edges -> addr_err=0 and instruccion=0x0000 without waiting for a clock edge. Release rst_n with counter=3 -> instruccion=0xCFC7.
